// File: rtl/clock_display_pkg.sv
// Shared definitions for the clock display refresh path.
//   seq_state_t : sequencer state encoding
//   SEG_TABLE   : 7-segment codes {g,f,e,d,c,b,a} for digits 0..9
//   SEG_DASH    : code shown for a non-decimal BCD nibble
//   SEG_BLANK   : all-off byte (leading-zero and blink blanking)
//   calc_half   : half-period of the serial clock in system clock cycles
package clock_display_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4,
        DONE     = 3'd5
    } seq_state_t;

    localparam int FRAME_W = 32;

    // Entry [n] is the segment pattern for digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Floor of sys/(2*shift), never below one cycle.
    function automatic int unsigned calc_half(input int unsigned sys_hz,
                                              input int unsigned shift_hz);
        int unsigned q;
        q = sys_hz / (2 * shift_hz);
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD to 7-segment decoder.
//   bcd : 4-bit digit value
//   seg : {g,f,e,d,c,b,a}, dash pattern for values above 9
module seven_seg_decoder
    import clock_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        if (bcd > 4'd9) begin
            seg = SEG_DASH;
        end else begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/display_refresh_sequencer.sv
// Serialises a four-digit HH:MM frame into an external shift register chain.
// A frame is captured in one cycle, shifted MSB first as 32 clock pairs of
// HALF system cycles per phase, then latched for HALF cycles.
//   i_clk, i_reset_n : system clock, asynchronous active-low reset
//   i_en             : block enable; low aborts any frame and clears requests
//   i_refresh        : single-cycle frame request (merged while busy)
//   i_hours_bcd      : {tens,ones} BCD hours
//   i_minutes_bcd    : {tens,ones} BCD minutes
//   i_blink_mask     : per-digit blink select, bit3 = hours tens
//   i_blink_phase    : high = blinked digits blanked
//   i_colon          : colon (hours-ones dp) lit
//   o_serial_data    : shift-register data
//   o_serial_clk     : shift-register clock
//   o_serial_latch   : shift-register storage strobe
//   o_busy           : frame in progress
//   o_done           : single-cycle frame-complete pulse
module display_refresh_sequencer
    import clock_display_pkg::*;
#(
    parameter int unsigned SYS_CLK_HZ   = 5_000_000,
    parameter int unsigned SHIFT_CLK_HZ = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic       i_refresh,
    input  logic [7:0] i_hours_bcd,
    input  logic [7:0] i_minutes_bcd,
    input  logic [3:0] i_blink_mask,
    input  logic       i_blink_phase,
    input  logic       i_colon,
    output logic       o_serial_data,
    output logic       o_serial_clk,
    output logic       o_serial_latch,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned HALF  = calc_half(SYS_CLK_HZ, SHIFT_CLK_HZ);
    localparam int          DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

    seq_state_t           state, state_n;
    logic [DIV_W-1:0]     div_cnt, div_n;
    logic [4:0]           bit_cnt, bit_n;
    logic                 pending, pending_n;
    logic [FRAME_W-1:0]   frame, frame_n, frame_enc;
    logic                 data_n, sclk_n, latch_n, done_n;
    logic                 div_last;

    logic [6:0] seg_ht, seg_ho, seg_mt, seg_mo;
    logic [7:0] byte_ht, byte_ho, byte_mt, byte_mo;
    logic [3:0] blank;

    seven_seg_decoder u_dec_ht (.bcd(i_hours_bcd[7:4]),   .seg(seg_ht));
    seven_seg_decoder u_dec_ho (.bcd(i_hours_bcd[3:0]),   .seg(seg_ho));
    seven_seg_decoder u_dec_mt (.bcd(i_minutes_bcd[7:4]), .seg(seg_mt));
    seven_seg_decoder u_dec_mo (.bcd(i_minutes_bcd[3:0]), .seg(seg_mo));

    // Frame encoding: blink blanking overrides everything, including the colon.
    always_comb begin
        blank   = i_blink_mask & {4{i_blink_phase}};
        byte_ht = (blank[3] || (i_hours_bcd[7:4] == 4'd0)) ? SEG_BLANK : {1'b0, seg_ht};
        byte_ho = blank[2] ? SEG_BLANK : {i_colon, seg_ho};
        byte_mt = blank[1] ? SEG_BLANK : {1'b0, seg_mt};
        byte_mo = blank[0] ? SEG_BLANK : {1'b0, seg_mo};
        frame_enc = {byte_ht, byte_ho, byte_mt, byte_mo};
    end

    assign div_last = (div_cnt == DIV_LAST);
    assign o_busy   = (state != IDLE);

    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        bit_n     = bit_cnt;
        pending_n = pending;
        frame_n   = frame;

        unique case (state)
            IDLE: begin
                if (i_refresh || pending) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                frame_n   = frame_enc;
                pending_n = 1'b0;
                div_n     = '0;
                bit_n     = '0;
                state_n   = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_last) begin
                    div_n   = '0;
                    state_n = SHIFT_HI;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    div_n = '0;
                    if (bit_cnt == 5'd31) begin
                        state_n = LATCH;
                    end else begin
                        bit_n   = bit_cnt + 5'd1;
                        state_n = SHIFT_LO;
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            LATCH: begin
                if (div_last) begin
                    div_n   = '0;
                    state_n = DONE;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A request that arrives while a frame is running is remembered once.
        if ((state != IDLE) && i_refresh) begin
            pending_n = 1'b1;
        end

        if (!i_en) begin
            state_n   = IDLE;
            pending_n = 1'b0;
            div_n     = '0;
            bit_n     = '0;
        end

        // Outputs are registered from the next state so they line up with it.
        data_n  = ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) ?
                  frame_n[5'd31 - bit_n] : 1'b0;
        sclk_n  = (state_n == SHIFT_HI);
        latch_n = (state_n == LATCH);
        done_n  = (state_n == DONE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            pending        <= 1'b0;
            frame          <= '0;
            o_serial_data  <= 1'b0;
            o_serial_clk   <= 1'b0;
            o_serial_latch <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            state          <= state_n;
            div_cnt        <= div_n;
            bit_cnt        <= bit_n;
            pending        <= pending_n;
            frame          <= frame_n;
            o_serial_data  <= data_n;
            o_serial_clk   <= sclk_n;
            o_serial_latch <= latch_n;
            o_done         <= done_n;
        end
    end

endmodule

// File: tb/tb_display_refresh_sequencer.sv
module tb_display_refresh_sequencer;

    localparam int HALF     = 5_000_000 / (2 * 1_000_000);
    localparam int BUSY_LEN = 2 + 65 * HALF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       refresh = 1'b0;
    logic [7:0] hours = 8'h00;
    logic [7:0] minutes = 8'h00;
    logic [3:0] mask = 4'h0;
    logic       phase = 1'b0;
    logic       colon = 1'b0;
    logic       sdata, sclk, slatch, busy, done;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    display_refresh_sequencer dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_refresh(refresh),
        .i_hours_bcd(hours), .i_minutes_bcd(minutes), .i_blink_mask(mask),
        .i_blink_phase(phase), .i_colon(colon),
        .o_serial_data(sdata), .o_serial_clk(sclk), .o_serial_latch(slatch),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: digit-by-digit display rules producing the 32-bit frame.
    function automatic logic [31:0] model_frame(input logic [7:0] h, input logic [7:0] m,
                                                input logic [3:0] mk, input logic ph,
                                                input logic cl);
        logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                     8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        logic [3:0]  d [4];
        logic [7:0]  code;
        logic [31:0] res;
        d[0] = h[7:4]; d[1] = h[3:0]; d[2] = m[7:4]; d[3] = m[3:0];
        res = '0;
        for (int i = 0; i < 4; i++) begin
            code = (d[i] > 4'd9) ? 8'h40 : seg_tab[d[i]];
            if (i == 0 && d[i] == 4'd0) code = 8'h00;
            if (i == 1) code[7] = cl;
            if (mk[3-i] && ph) code = 8'h00;
            res = {res[23:0], code};
        end
        return res;
    endfunction

    task automatic start_frame(input logic [7:0] h, input logic [7:0] m,
                               input logic [3:0] mk, input logic ph, input logic cl);
        @(negedge clk);
        hours = h; minutes = m; mask = mk; phase = ph; colon = cl; refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        check(busy == 1'b1, "busy_rise", 32'(busy), 32'd1);
        @(negedge clk);
        // Scramble inputs once the frame is captured; the frame must not change.
        hours = 8'($urandom); minutes = 8'($urandom); mask = 4'($urandom);
        phase = 1'($urandom); colon = 1'($urandom);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(!busy, name, 32'(busy), 32'd0);
    endtask

    // Monitor: reassembles shifted frames and pops the scoreboard on each latch.
    initial begin
        logic [31:0] shreg, e;
        int nbits, latch_len, busy_len;
        logic prev_clk, prev_latch, prev_busy, latched, done_seen;
        shreg = '0; nbits = 0; latch_len = 0; busy_len = 0;
        prev_clk = 0; prev_latch = 0; prev_busy = 0; latched = 0; done_seen = 0;
        forever begin
            @(negedge clk);
            if (sclk && !prev_clk) begin
                shreg = {shreg[30:0], sdata};
                nbits++;
            end
            if (slatch) latch_len++;
            if (prev_latch && !slatch) begin
                check(latch_len == HALF, "latch_len", 32'(latch_len), 32'(HALF));
                check(nbits == 32, "bit_count", 32'(nbits), 32'd32);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_frame", shreg, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(shreg == e, "frame", shreg, e);
                end
                latched = 1; latch_len = 0; nbits = 0;
            end
            if (busy) busy_len++;
            if (done) begin
                check(busy_len == BUSY_LEN && latched, "done_timing", 32'(busy_len), 32'(BUSY_LEN));
                done_seen = 1; latched = 0;
            end
            if (!busy) begin
                if (prev_busy && !done_seen) begin
                    nbits = 0; latch_len = 0; latched = 0;
                end
                done_seen = 0; busy_len = 0;
                check({sdata, sclk, slatch, done} == 4'b0, "idle_outputs",
                      32'({sdata, sclk, slatch, done}), 32'd0);
            end
            prev_clk = sclk; prev_latch = slatch; prev_busy = busy;
        end
    end

    initial begin
        int n;
        bit rose;
        logic [7:0] h, m;
        logic [3:0] mk;
        logic ph, cl;

        // Reset state
        #2 rst_n = 1'b0;
        #1 check({sdata, sclk, slatch, busy, done} == 5'b0, "reset_outputs",
                 32'({sdata, sclk, slatch, busy, done}), 32'd0);
        en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check(!busy, "idle_after_reset", 32'(busy), 32'd0);

        // Directed frames
        exp_q.push_back(32'h06DB4F66);
        start_frame(8'h12, 8'h34, 4'b0000, 1'b0, 1'b1);
        wait_idle(300, "frame_1234");
        exp_q.push_back(32'h006F0000);
        start_frame(8'h09, 8'h59, 4'b0011, 1'b1, 1'b0);
        wait_idle(300, "frame_blink");
        exp_q.push_back(32'h06403F3F);
        start_frame(8'h1A, 8'h00, 4'b0000, 1'b0, 1'b0);
        wait_idle(300, "frame_dash");

        // Random frames
        for (int i = 0; i < 8; i++) begin
            h = 8'($urandom); m = 8'($urandom); mk = 4'($urandom);
            ph = 1'($urandom); cl = 1'($urandom);
            if (i % 2 == 0) h[7:4] = 4'($urandom_range(0, 2));
            exp_q.push_back(model_frame(h, m, mk, ph, cl));
            start_frame(h, m, mk, ph, cl);
            wait_idle(300, "frame_random");
        end

        // Merged requests during a frame yield exactly one extra frame
        exp_q.push_back(model_frame(8'h23, 8'h45, 4'b0000, 1'b0, 1'b1));
        start_frame(8'h23, 8'h45, 4'b0000, 1'b0, 1'b1);
        repeat (48) @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        repeat (8) @(negedge clk);
        hours = 8'h07; minutes = 8'h08; mask = 4'b0100; phase = 1'b0; colon = 1'b0;
        refresh = 1'b1;
        exp_q.push_back(model_frame(8'h07, 8'h08, 4'b0100, 1'b0, 1'b0));
        @(negedge clk);
        refresh = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(done, "done_seen", 32'(done), 32'd1);
        @(negedge clk);
        check(!busy, "gap_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check(busy, "pending_start", 32'(busy), 32'd1);
        wait_idle(300, "pending_frame");
        rose = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy) rose = 1;
        end
        check(!rose, "no_third_frame", 32'(rose), 32'd0);

        // Enable dropped around bit 10 with a request pending
        start_frame(8'h11, 8'h22, 4'b0000, 1'b0, 1'b1);
        repeat (18) @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b0;
        refresh = 1'b1;
        @(negedge clk);
        check({sdata, sclk, slatch, busy, done} == 5'b0, "en_drop_outputs",
              32'({sdata, sclk, slatch, busy, done}), 32'd0);
        rose = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy) rose = 1;
        end
        check(!rose, "refresh_ignored_disabled", 32'(rose), 32'd0);
        refresh = 1'b0;
        en = 1'b1;
        rose = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) rose = 1;
        end
        check(!rose, "en_pending_cleared", 32'(rose), 32'd0);

        // Asynchronous reset during a SHIFT_HI phase, with a request pending
        start_frame(8'h05, 8'h43, 4'b0000, 1'b0, 1'b1);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        n = 0;
        while (!sclk && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(sclk, "reached_shift_hi", 32'(sclk), 32'd1);
        #2 rst_n = 1'b0;
        #1 check({sdata, sclk, slatch, busy, done} == 5'b0, "async_reset_outputs",
                 32'({sdata, sclk, slatch, busy, done}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rose = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) rose = 1;
        end
        check(!rose, "reset_pending_cleared", 32'(rose), 32'd0);

        // Normal operation resumes after reset
        exp_q.push_back(model_frame(8'h10, 8'h9B, 4'b1000, 1'b1, 1'b1));
        start_frame(8'h10, 8'h9B, 4'b1000, 1'b1, 1'b1);
        wait_idle(300, "frame_after_reset");

        repeat (5) @(negedge clk);
        check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
